uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_rx_os_if.sv | 15 +
 rtl/uart_rx_os.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// Receive-side bus bundle of the oversampling UART receiver: payload, constant address,
// write strobe, error pulses and busy flag.
interface uart_rx_os_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_out;
   logic [31:0]          address;
   logic                 we;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;

   modport master (output data_out, address, we, parity_err, frame_err, busy);
   modport slave  (input  data_out, address, we, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, tick divider, 2-of-3 majority vote per bit,
// optional parity, 1-2 stop bits and line-break recovery before new starts are accepted.
module uart_rx_os #(
   parameter int unsigned CLK_FREQ   = 1600000,
   parameter int unsigned BAUD       = 10000,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 2,
   parameter int unsigned STOP_BITS  = 1,
   parameter logic [31:0] ADDRESS    = 32'h0040_0100
) (
   input logic          clk,
   input logic          reset,
   input logic          rx_in,
   uart_rx_os_if.master bus
);
   localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] TICK_A    = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_B    = TICK_W'(OVERSAMPLE / 2);
   localparam logic [TICK_W-1:0] TICK_C    = TICK_W'(OVERSAMPLE / 2 + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StWaitHigh} state_e;

   state_e               state_q, state_d;
   logic [1:0]           sync_q;
   logic                 line_prev_q;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 s0_q, s0_d, s1_q, s1_d;
   logic                 par_flag_q, par_flag_d, frame_flag_q, frame_flag_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 we_q, we_d, perr_q, perr_d, ferr_q, ferr_d;

   logic line, tick, decide, vote, par_exp, frame_now;

   assign line      = sync_q[1];
   assign tick      = (state_q != StIdle) && (div_q == '0);
   assign decide    = tick && (tick_q == TICK_C);
   assign vote      = (s0_q & s1_q) | (s0_q & line) | (s1_q & line);
   assign par_exp   = (^shift_q) ^ (PARITY == 1);
   assign frame_now = frame_flag_q | ~vote;

   always_comb begin
      state_d      = state_q;
      div_d        = '0;
      tick_d       = tick_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      s0_d         = s0_q;
      s1_d         = s1_q;
      par_flag_d   = par_flag_q;
      frame_flag_d = frame_flag_q;
      data_d       = data_q;
      we_d         = 1'b0;
      perr_d       = 1'b0;
      ferr_d       = 1'b0;

      if (state_q != StIdle) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      if (tick) begin
         tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
         if (tick_q == TICK_A) s0_d = line;
         if (tick_q == TICK_B) s1_d = line;
      end

      case (state_q)
         StIdle: begin
            if (!line && line_prev_q) begin
               state_d      = StStart;
               tick_d       = '0;
               bit_d        = '0;
               par_flag_d   = 1'b0;
               frame_flag_d = 1'b0;
            end
         end
         StStart: begin
            if (decide) state_d = vote ? StIdle : StData;
         end
         StData: begin
            if (decide) begin
               shift_d = {vote, shift_q[DATA_BITS-1:1]};
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? StPar : StStop;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         StPar: begin
            if (decide) begin
               if (vote != par_exp) par_flag_d = 1'b1;
               state_d = StStop;
            end
         end
         StStop: begin
            if (decide) begin
               frame_flag_d = frame_now;
               if (bit_q == STOP_LAST) begin
                  // Finish mid stop bit so an immediately following start edge is seen in idle
                  data_d  = shift_q;
                  we_d    = !par_flag_q && !frame_now;
                  perr_d  = par_flag_q;
                  ferr_d  = frame_now;
                  tick_d  = '0;
                  state_d = frame_now ? StWaitHigh : StIdle;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         StWaitHigh: begin
            // tick_q counts consecutive high samples; a low sample restarts the bit period
            if (tick) begin
               if (!line) tick_d = '0;
               else if (tick_q == TICK_LAST) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q       <= 2'b11;
         line_prev_q  <= 1'b1;
         state_q      <= StIdle;
         div_q        <= '0;
         tick_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         s0_q         <= 1'b0;
         s1_q         <= 1'b0;
         par_flag_q   <= 1'b0;
         frame_flag_q <= 1'b0;
         data_q       <= '0;
         we_q         <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], rx_in};
         line_prev_q  <= line;
         state_q      <= state_d;
         div_q        <= div_d;
         tick_q       <= tick_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         s0_q         <= s0_d;
         s1_q         <= s1_d;
         par_flag_q   <= par_flag_d;
         frame_flag_q <= frame_flag_d;
         data_q       <= data_d;
         we_q         <= we_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.address    = ADDRESS;
   assign bus.we         = we_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.busy       = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed and random frames on a default receiver plus a 7N2 receiver,
// checked against expectations computed from frame contents.
module tb_uart_rx_os;
   localparam int DIV = 10;
   localparam int BIT = 160;
   localparam int GAP = 220;

   logic clk, reset0, reset1, rx0, rx1;
   int   cyc = 0;
   int   n_checks = 0, n_errors = 0;

   uart_rx_os_if #(.DATA_BITS(8)) bus0 ();
   uart_rx_os_if #(.DATA_BITS(7)) bus1 ();

   uart_rx_os u_dut0 (.clk(clk), .reset(reset0), .rx_in(rx0), .bus(bus0));
   uart_rx_os #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .reset(reset1), .rx_in(rx1), .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitors
   int         we_cnt0 = 0, pe_cnt0 = 0, fe_cnt0 = 0, we_cyc0 = 0, dbl0 = 0;
   int         we_cnt1 = 0, pe_cnt1 = 0, fe_cnt1 = 0, dbl1 = 0;
   logic [2:0] prev0 = '0, prev1 = '0;
   logic [6:0] we_log1[$];

   always @(negedge clk) begin
      if (bus0.we) begin
         we_cnt0 <= we_cnt0 + 1;
         we_cyc0 <= cyc;
      end
      if (bus0.parity_err) pe_cnt0 <= pe_cnt0 + 1;
      if (bus0.frame_err)  fe_cnt0 <= fe_cnt0 + 1;
      if ((prev0 & {bus0.we, bus0.parity_err, bus0.frame_err}) != 3'b000) dbl0 <= dbl0 + 1;
      prev0 <= {bus0.we, bus0.parity_err, bus0.frame_err};
      if (bus1.we) begin
         we_cnt1 <= we_cnt1 + 1;
         we_log1.push_back(bus1.data_out);
      end
      if (bus1.parity_err) pe_cnt1 <= pe_cnt1 + 1;
      if (bus1.frame_err)  fe_cnt1 <= fe_cnt1 + 1;
      if ((prev1 & {bus1.we, bus1.parity_err, bus1.frame_err}) != 3'b000) dbl1 <= dbl1 + 1;
      prev1 <= {bus1.we, bus1.parity_err, bus1.frame_err};
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx0 = v;
      else rx1 = v;
   endtask

   // Sends n bits LSB first; spike 1 = one-clock inversion at the bit centre,
   // spike 2 = one-clock inversion at a random point near the centre.
   task automatic send_bits(input int which, input logic [15:0] bits, input int n, input int spike);
      int off;
      for (int i = 0; i < n; i++) begin
         set_rx(which, bits[i]);
         if (spike == 0) begin
            repeat (BIT) @(posedge clk);
         end else begin
            off = (spike == 1) ? BIT / 2 : int'($urandom_range(66, 96));
            repeat (off) @(posedge clk);
            #1 set_rx(which, ~bits[i]);
            @(posedge clk);
            #1 set_rx(which, bits[i]);
            repeat (BIT - off - 1) @(posedge clk);
         end
         #1;
      end
   endtask

   // Model: even parity expected; a good frame needs matching parity and a high stop bit.
   task automatic frame0(input string tag, input logic [7:0] pl, input logic pb, input logic sb,
                         input int spike);
      int   we_b, pe_b, fe_b, c0, centre, lat;
      logic par_ok, good;
      we_b = we_cnt0; pe_b = pe_cnt0; fe_b = fe_cnt0; c0 = cyc;
      send_bits(0, 16'({sb, pb, pl, 1'b0}), 11, spike);
      set_rx(0, 1'b1);
      repeat (GAP) @(posedge clk);
      #1;
      par_ok = (pb == ^pl);
      good   = par_ok && sb;
      check_eq({tag, "_we"},   32'(we_cnt0 - we_b), good ? 32'd1 : 32'd0);
      check_eq({tag, "_perr"}, 32'(pe_cnt0 - pe_b), par_ok ? 32'd0 : 32'd1);
      check_eq({tag, "_ferr"}, 32'(fe_cnt0 - fe_b), sb ? 32'd0 : 32'd1);
      check_eq({tag, "_data"}, 32'(bus0.data_out), 32'(pl));
      if (good) begin
         // Vote completes one tick past the stop-bit centre; strobe follows 2-4 clocks later
         centre = c0 + 1 + 10 * BIT + BIT / 2;
         lat    = we_cyc0 - centre;
         check_eq({tag, "_lat"}, 32'(lat >= DIV + 2 && lat <= DIV + 4), 32'd1);
      end
   endtask

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int          we_b, pe_b, fe_b;
      logic [7:0]  pl;
      logic        pb, sb;
      reset0 = 1'b1; reset1 = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(bus0.busy), 32'd0);
      check_eq("rst_we",   32'(bus0.we), 32'd0);
      check_eq("rst_perr", 32'(bus0.parity_err), 32'd0);
      check_eq("rst_ferr", 32'(bus0.frame_err), 32'd0);
      check_eq("rst_data", 32'(bus0.data_out), 32'd0);
      check_eq("rst_addr", bus0.address, 32'h0040_0100);
      check_eq("rst_addr1", bus1.address, 32'h0040_0100);
      reset0 = 1'b0; reset1 = 1'b0;
      @(posedge clk);
      #1;

      frame0("good_5a", 8'h5A, 1'b0, 1'b1, 0);
      frame0("bad_par_5a", 8'h5A, 1'b1, 1'b1, 0);

      // Line break: held low for 20 bit times
      we_b = we_cnt0; pe_b = pe_cnt0; fe_b = fe_cnt0;
      set_rx(0, 1'b0);
      repeat (20 * BIT) @(posedge clk);
      #1;
      check_eq("brk_ferr", 32'(fe_cnt0 - fe_b), 32'd1);
      check_eq("brk_perr", 32'(pe_cnt0 - pe_b), 32'd0);
      check_eq("brk_we",   32'(we_cnt0 - we_b), 32'd0);
      check_eq("brk_busy", 32'(bus0.busy), 32'd1);
      check_eq("brk_data", 32'(bus0.data_out), 32'd0);
      set_rx(0, 1'b1);
      repeat (100) @(posedge clk);
      #1;
      check_eq("brk_wait_busy", 32'(bus0.busy), 32'd1);
      repeat (120) @(posedge clk);
      #1;
      check_eq("brk_idle_busy", 32'(bus0.busy), 32'd0);
      frame0("after_brk_a5", 8'hA5, 1'b0, 1'b1, 0);

      // 40-clock low glitch in idle
      we_b = we_cnt0; pe_b = pe_cnt0; fe_b = fe_cnt0;
      set_rx(0, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      check_eq("glitch_busy", 32'(bus0.busy), 32'd1);
      repeat (20) @(posedge clk);
      #1 set_rx(0, 1'b1);
      repeat (GAP) @(posedge clk);
      #1;
      check_eq("glitch_idle", 32'(bus0.busy), 32'd0);
      check_eq("glitch_pulses", 32'((we_cnt0 - we_b) + (pe_cnt0 - pe_b) + (fe_cnt0 - fe_b)), 32'd0);
      check_eq("glitch_data", 32'(bus0.data_out), 32'hA5);

      frame0("spike_3c", 8'h3C, 1'b0, 1'b1, 1);
      frame0("rspike_3c", 8'h3C, 1'b0, 1'b1, 2);

      for (int i = 0; i < 10; i++) begin
         pl = 8'($urandom);
         pb = (^pl) ^ ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 5) != 0);
         frame0($sformatf("rnd%0d", i), pl, pb, sb, int'($urandom_range(0, 2)));
      end

      // 7N2 receiver: back-to-back frames
      we_b = we_cnt1; pe_b = pe_cnt1; fe_b = fe_cnt1;
      send_bits(1, 16'({2'b11, 7'h11, 1'b0}), 10, 0);
      send_bits(1, 16'({2'b11, 7'h7F, 1'b0}), 10, 0);
      set_rx(1, 1'b1);
      repeat (GAP) @(posedge clk);
      #1;
      check_eq("b2b_we", 32'(we_cnt1 - we_b), 32'd2);
      check_eq("b2b_errs", 32'((pe_cnt1 - pe_b) + (fe_cnt1 - fe_b)), 32'd0);
      check_eq("b2b_n", 32'(we_log1.size()), 32'd2);
      check_eq("b2b_d0", 32'(we_log1[0]), 32'h11);
      check_eq("b2b_d1", 32'(we_log1[1]), 32'h7F);

      // Same pair again with reset asserted during the second frame
      we_b = we_cnt1;
      fork
         begin
            send_bits(1, 16'({2'b11, 7'h11, 1'b0}), 10, 0);
            send_bits(1, 16'({2'b11, 7'h7F, 1'b0}), 10, 0);
         end
         begin
            repeat (12 * BIT + 40) @(posedge clk);
            #2 reset1 = 1'b1;
            repeat (2) @(posedge clk);
            #2;
            check_eq("mid_rst_data", 32'(bus1.data_out), 32'd0);
            check_eq("mid_rst_busy", 32'(bus1.busy), 32'd0);
            check_eq("mid_rst_we",   32'(bus1.we), 32'd0);
            check_eq("mid_rst_errs", 32'({bus1.parity_err, bus1.frame_err}), 32'd0);
            repeat (18) @(posedge clk);
            #2 reset1 = 1'b0;
         end
      join
      set_rx(1, 1'b1);
      repeat (GAP) @(posedge clk);
      #1;
      check_eq("rst_b2b_we", 32'(we_cnt1 - we_b), 32'd1);
      check_eq("rst_b2b_d", 32'(we_log1[2]), 32'h11);
      check_eq("rst_b2b_data", 32'(bus1.data_out), 32'd0);
      check_eq("rst_b2b_busy", 32'(bus1.busy), 32'd0);

      check_eq("pulse_width0", 32'(dbl0), 32'd0);
      check_eq("pulse_width1", 32'(dbl1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
